// File: rtl/reflet_arb_pkg.sv
// reflet_arb_pkg: shared FSM state encoding and master indices
// for the reflet memory arbiter and its round-robin picker.
package reflet_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } arb_state_e;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

endpackage

// File: rtl/reflet_mem_arbiter_if.sv
// reflet_mem_arbiter_if: two req/ack master ports plus the shared
// memory bus. slave = arbiter side, master = masters/memory side.
interface reflet_mem_arbiter_if #(
  parameter int wordsize = 16
);
  logic                req0;
  logic [wordsize-1:0] addr0;
  logic [wordsize-1:0] wdata0;
  logic                we0;
  logic                lock0;
  logic                ack0;
  logic [wordsize-1:0] rdata0;

  logic                req1;
  logic [wordsize-1:0] addr1;
  logic [wordsize-1:0] wdata1;
  logic                we1;
  logic                lock1;
  logic                ack1;
  logic [wordsize-1:0] rdata1;

  logic [wordsize-1:0] mem_addr;
  logic [wordsize-1:0] mem_wdata;
  logic                mem_we;
  logic [wordsize-1:0] mem_rdata;
  logic                busy;

  modport slave (
    input  req0, addr0, wdata0, we0, lock0,
    output ack0, rdata0,
    input  req1, addr1, wdata1, we1, lock1,
    output ack1, rdata1,
    output mem_addr, mem_wdata, mem_we, busy,
    input  mem_rdata
  );

  modport master (
    output req0, addr0, wdata0, we0, lock0,
    input  ack0, rdata0,
    output req1, addr1, wdata1, we1, lock1,
    input  ack1, rdata1,
    input  mem_addr, mem_wdata, mem_we, busy,
    output mem_rdata
  );
endinterface

// File: rtl/reflet_rr_pick.sv
// reflet_rr_pick: combinational 2-way round-robin picker.
// In: req0_i/req1_i, owner_i, lock_hold_i. Out: grant_valid_o, grant_idx_o.
module reflet_rr_pick
  import reflet_arb_pkg::*;
(
  input  logic req0_i,
  input  logic req1_i,
  input  logic owner_i,
  input  logic lock_hold_i,
  output logic grant_valid_o,
  output logic grant_idx_o
);

  always_comb begin
    grant_valid_o = 1'b0;
    grant_idx_o   = M0;
    if (lock_hold_i) begin
      // Locked bus: only the last owner may be granted.
      grant_valid_o = owner_i ? req1_i : req0_i;
      grant_idx_o   = owner_i;
    end else if (req0_i && req1_i) begin
      grant_valid_o = 1'b1;
      grant_idx_o   = !owner_i;
    end else if (req1_i) begin
      grant_valid_o = 1'b1;
      grant_idx_o   = M1;
    end else if (req0_i) begin
      grant_valid_o = 1'b1;
      grant_idx_o   = M0;
    end
  end

endmodule

// File: rtl/reflet_mem_arbiter.sv
// reflet_mem_arbiter: two-master round-robin arbiter onto one
// sync-read memory bus (OR-bus: mem outputs zero when idle).
// Ports: clk, reset (sync, active-high), bus (slave modport).
// Optional bus lock for atomic sequences: REFLET_ARB_LOCK_EN.
module reflet_mem_arbiter
  import reflet_arb_pkg::*;
#(
  parameter int wordsize    = 16,
  parameter int mem_latency = 1
) (
  input logic                 clk,
  input logic                 reset,
  reflet_mem_arbiter_if.slave bus
);

  arb_state_e          state_q, state_d;
  logic                owner_q, owner_d;
  logic                lock_hold_q;
  logic                ack_hold;
  logic                grant_valid, grant_idx;
  logic                issue_act, ack_act;
  logic                own_we, other_req;
  logic [wordsize-1:0] own_addr, own_wdata, own_rdata;

  assign own_addr  = owner_q ? bus.addr1  : bus.addr0;
  assign own_wdata = owner_q ? bus.wdata1 : bus.wdata0;
  assign own_we    = owner_q ? bus.we1    : bus.we0;
  assign other_req = owner_q ? bus.req0   : bus.req1;

  reflet_rr_pick u_pick (
    .req0_i        (bus.req0),
    .req1_i        (bus.req1),
    .owner_i       (owner_q),
    .lock_hold_i   (lock_hold_q),
    .grant_valid_o (grant_valid),
    .grant_idx_o   (grant_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= M1;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

`ifdef REFLET_ARB_LOCK_EN
  logic own_lock;
  logic lock_hold_d;

  assign own_lock = owner_q ? bus.lock1 : bus.lock0;
  assign ack_hold = own_lock;

  always_ff @(posedge clk) begin
    if (reset) lock_hold_q <= 1'b0;
    else       lock_hold_q <= lock_hold_d;
  end

  // Every ACK re-decides the hold from the owner's lock.
  always_comb begin
    lock_hold_d = lock_hold_q;
    if (state_q == ACK) lock_hold_d = own_lock;
  end
`else
  logic unused_lock;

  assign unused_lock = bus.lock0 ^ bus.lock1;
  assign ack_hold    = 1'b0;
  assign lock_hold_q = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    unique case (state_q)
      IDLE: begin
        if (grant_valid) begin
          owner_d = grant_idx;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = (mem_latency == 2) ? WAIT : ACK;
      WAIT:  state_d = ACK;
      ACK: begin
        // Owner's req is ignored here; hand straight to the other.
        state_d = IDLE;
        if (other_req && !ack_hold) begin
          owner_d = !owner_q;
          state_d = ISSUE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Gating with reset keeps an aborted access off the bus.
  assign issue_act = (state_q == ISSUE) && !reset;
  assign ack_act   = (state_q == ACK) && !reset;

  assign bus.mem_addr  = issue_act ? own_addr : '0;
  assign bus.mem_wdata = issue_act ? own_wdata : '0;
  assign bus.mem_we    = issue_act && own_we;

  assign own_rdata  = own_we ? '0 : bus.mem_rdata;
  assign bus.ack0   = ack_act && (owner_q == M0);
  assign bus.ack1   = ack_act && (owner_q == M1);
  assign bus.rdata0 = (ack_act && owner_q == M0) ? own_rdata : '0;
  assign bus.rdata1 = (ack_act && owner_q == M1) ? own_rdata : '0;
  assign bus.busy   = (state_q != IDLE) && !reset;

endmodule

// File: tb/tb_reflet_mem_arbiter.sv
// tb_reflet_mem_arbiter: directed + random checks of two arbiters
// (mem_latency 1 and 2) against a sync-read memory model.
module tb_reflet_mem_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        req[2][2], we[2][2], lock[2][2], ack[2][2];
  logic [15:0] addr[2][2], wdata[2][2], rdata[2][2];
  logic [15:0] maddr[2], mwdata[2], mrdata[2];
  logic        mwe[2], busy[2];

  logic [15:0] ram[2][256];
  logic [15:0] shadow[2][256];
  logic [15:0] rd1[2], rd2[2];
  logic        pl_en;
  logic [7:0]  pl_addr;
  logic [15:0] pl_data;

  int checks = 0;
  int failures = 0;

  for (genvar k = 0; k < 2; k++) begin : g
    reflet_mem_arbiter_if #(.wordsize(16)) bus ();
    assign bus.req0      = req[k][0];
    assign bus.addr0     = addr[k][0];
    assign bus.wdata0    = wdata[k][0];
    assign bus.we0       = we[k][0];
    assign bus.lock0     = lock[k][0];
    assign bus.req1      = req[k][1];
    assign bus.addr1     = addr[k][1];
    assign bus.wdata1    = wdata[k][1];
    assign bus.we1       = we[k][1];
    assign bus.lock1     = lock[k][1];
    assign bus.mem_rdata = mrdata[k];
    assign ack[k][0]     = bus.ack0;
    assign ack[k][1]     = bus.ack1;
    assign rdata[k][0]   = bus.rdata0;
    assign rdata[k][1]   = bus.rdata1;
    assign maddr[k]      = bus.mem_addr;
    assign mwdata[k]     = bus.mem_wdata;
    assign mwe[k]        = bus.mem_we;
    assign busy[k]       = bus.busy;
    assign mrdata[k]     = (k == 0) ? rd1[k] : rd2[k];

    reflet_mem_arbiter #(
      .wordsize    (16),
      .mem_latency (k + 1)
    ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
    );
  end

  // Sync-read RAM: one register stage per cycle of latency.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (mwe[k]) ram[k][maddr[k][7:0]] <= mwdata[k];
      rd1[k] <= ram[k][maddr[k][7:0]];
      rd2[k] <= rd1[k];
    end
    if (pl_en) begin
      ram[0][pl_addr] <= pl_data;
      ram[1][pl_addr] <= pl_data;
    end
  end

  task automatic chk16(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clr_all;
    for (int k = 0; k < 2; k++) begin
      for (int m = 0; m < 2; m++) begin
        req[k][m] = 1'b0; we[k][m] = 1'b0; lock[k][m] = 1'b0;
        addr[k][m] = 16'h0; wdata[k][m] = 16'h0;
      end
    end
  endtask

  task automatic do_reset;
    clr_all();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic preload(input logic [7:0] a, input logic [15:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    tick();
    pl_en = 1'b0;
    shadow[0][a] = d;
    shadow[1][a] = d;
  endtask

  task automatic chk_idle(input int k, input string tag);
    chk1({tag, "_busy"}, busy[k], 1'b0);
    chk16({tag, "_maddr"}, maddr[k], 16'h0);
    chk16({tag, "_mwdata"}, mwdata[k], 16'h0);
    chk1({tag, "_mwe"}, mwe[k], 1'b0);
    chk1({tag, "_ack0"}, ack[k][0], 1'b0);
    chk1({tag, "_ack1"}, ack[k][1], 1'b0);
    chk16({tag, "_rdata0"}, rdata[k][0], 16'h0);
    chk16({tag, "_rdata1"}, rdata[k][1], 16'h0);
  endtask

  // One isolated access, checked cycle by cycle.
  task automatic access(input int k, input int m, input logic [15:0] a,
                        input logic [15:0] d, input logic w);
    req[k][m] = 1'b1; addr[k][m] = a; wdata[k][m] = d; we[k][m] = w;
    #1 chk_idle(k, "acc_t0");
    tick();
    #1 chk16("acc_issue_addr", maddr[k], a);
    chk16("acc_issue_wdata", mwdata[k], d);
    chk1("acc_issue_we", mwe[k], w);
    chk1("acc_issue_busy", busy[k], 1'b1);
    chk1("acc_issue_ack", ack[k][m], 1'b0);
    tick();
    if (k == 1) begin
      #1 chk16("acc_wait_addr", maddr[k], 16'h0);
      chk1("acc_wait_we", mwe[k], 1'b0);
      chk1("acc_wait_ack", ack[k][m], 1'b0);
      chk1("acc_wait_busy", busy[k], 1'b1);
      tick();
    end
    #1 chk1("acc_ack", ack[k][m], 1'b1);
    chk1("acc_ack_other", ack[k][1-m], 1'b0);
    chk16("acc_rdata", rdata[k][m], w ? 16'h0 : shadow[k][a[7:0]]);
    chk16("acc_ack_maddr", maddr[k], 16'h0);
    chk1("acc_ack_we", mwe[k], 1'b0);
    if (w) shadow[k][a[7:0]] = d;
    tick();
    req[k][m] = 1'b0; we[k][m] = 1'b0;
    #1 chk_idle(k, "acc_end");
  endtask

  int          pend[2], gcyc[2], acyc[2], foreign[2][2];
  logic        last[2];
  logic        active[2][2];
  int          em;
  logic        issue, sel, win;
  logic        got_q[$];
  logic        gm;
  logic        lock_exp[4];

  initial begin
    reset = 1'b1; pl_en = 1'b0; pl_addr = 8'h0; pl_data = 16'h0;
    clr_all();
    @(negedge clk);
    tick();
    #1 chk_idle(0, "rst0");
    chk_idle(1, "rst1");
    reset = 1'b0;

    preload(8'h04, 16'hBEEF);
    preload(8'h20, 16'h5555);
    preload(8'h30, 16'hA0A0);
    preload(8'h31, 16'hB1B1);

    for (int k = 0; k < 2; k++) begin
      access(k, 0, 16'h8004, 16'h0, 1'b0);
      access(k, 1, 16'h8010, 16'h1234, 1'b1);
      chk16("wr_ram", ram[k][8'h10], 16'h1234);
      access(k, 0, 16'h8010, 16'h0, 1'b0);
    end

    // Both held from reset: 0,1,0,1 back to back.
    for (int k = 0; k < 2; k++) begin
      do_reset();
      req[k][0] = 1'b1; addr[k][0] = 16'h8030;
      req[k][1] = 1'b1; addr[k][1] = 16'h8031;
      #1 chk1("cont_idle_busy", busy[k], 1'b0);
      tick();
      for (int i = 0; i < 4; i++) begin
        #1 chk16("cont_issue_addr", maddr[k], 16'h8030 + 16'(i % 2));
        chk1("cont_issue_busy", busy[k], 1'b1);
        tick();
        if (k == 1) begin
          #1 chk16("cont_wait_addr", maddr[k], 16'h0);
          tick();
        end
        if (i == 3) req[k][0] = 1'b0;
        #1 chk1("cont_ack", ack[k][i % 2], 1'b1);
        chk1("cont_ack_other", ack[k][1 - (i % 2)], 1'b0);
        chk16("cont_rdata", rdata[k][i % 2], shadow[k][8'h30 + 8'(i % 2)]);
        chk1("cont_ack_busy", busy[k], 1'b1);
        tick();
      end
      req[k][1] = 1'b0;
      #1 chk1("cont_done_busy", busy[k], 1'b0);
    end

    // Reset during the ISSUE of a write.
    for (int k = 0; k < 2; k++) begin
      req[k][0] = 1'b1; we[k][0] = 1'b1;
      addr[k][0] = 16'h8020; wdata[k][0] = 16'hDEAD;
      tick();
      reset = 1'b1;
      #1 chk1("rst_mid_we", mwe[k], 1'b0);
      tick();
      reset = 1'b0; req[k][0] = 1'b0; we[k][0] = 1'b0;
      #1 chk1("rst_mid_busy", busy[k], 1'b0);
      for (int i = 0; i < 3; i++) begin
        #1 chk1("rst_mid_ack", ack[k][0], 1'b0);
        tick();
      end
      chk16("rst_mid_ram", ram[k][8'h20], 16'h5555);
    end

`ifdef REFLET_ARB_LOCK_EN
    lock_exp[0] = 1'b0; lock_exp[1] = 1'b0;
    lock_exp[2] = 1'b0; lock_exp[3] = 1'b1;
    for (int k = 0; k < 2; k++) begin
      int n0;
      do_reset();
      got_q.delete();
      n0 = 0;
      req[k][0] = 1'b1; addr[k][0] = 16'h8030;
      req[k][1] = 1'b1; addr[k][1] = 16'h8031;
      for (int c = 0; c < 40 && got_q.size() < 4; c++) begin
        lock[k][0] = (n0 < 2);
        if (n0 == 3) req[k][0] = 1'b0;
        #1;
        if (ack[k][0] === 1'b1) begin got_q.push_back(1'b0); n0++; end
        if (ack[k][1] === 1'b1) got_q.push_back(1'b1);
        tick();
      end
      for (int i = 0; i < 4; i++) begin
        gm = (i < got_q.size()) ? got_q[i] : 1'bx;
        chk1("lock_order", gm, lock_exp[i]);
      end
      clr_all();
      for (int i = 0; i < 6; i++) tick();
    end
`endif

    // Random traffic against a transaction-timing model.
    do_reset();
    for (int i = 0; i < 8; i++) preload(8'h40 + 8'(i), 16'($urandom));
    for (int k = 0; k < 2; k++) begin
      pend[k] = -1; gcyc[k] = 0; acyc[k] = 0; last[k] = 1'b1;
      for (int m = 0; m < 2; m++) begin
        active[k][m] = 1'b0; foreign[k][m] = 0;
      end
    end
    for (int cyc = 0; cyc < 300; cyc++) begin
      for (int k = 0; k < 2; k++) begin
        for (int m = 0; m < 2; m++) begin
          if (!active[k][m] && $urandom_range(0, 2) == 0) begin
            active[k][m] = 1'b1;
            req[k][m]    = 1'b1;
            addr[k][m]   = 16'h8040 + 16'($urandom_range(0, 7));
            we[k][m]     = 1'($urandom_range(0, 1));
            wdata[k][m]  = 16'($urandom);
          end
        end
      end
      #1;
      for (int k = 0; k < 2; k++) begin
        em    = (pend[k] >= 0 && cyc == acyc[k]) ? pend[k] : -1;
        issue = (pend[k] >= 0 && cyc == gcyc[k] + 1);
        sel   = (pend[k] == 1);
        chk1("r_ack0", ack[k][0], em == 0);
        chk1("r_ack1", ack[k][1], em == 1);
        chk16("r_maddr", maddr[k], issue ? addr[k][sel] : 16'h0);
        chk16("r_mwdata", mwdata[k], issue ? wdata[k][sel] : 16'h0);
        chk1("r_mwe", mwe[k], issue && we[k][sel]);
        chk1("r_busy", busy[k], pend[k] >= 0 && cyc > gcyc[k]);
        for (int m = 0; m < 2; m++) begin
          chk16("r_rdata", rdata[k][m], (em == m && !we[k][m]) ?
                shadow[k][addr[k][m][7:0]] : 16'h0);
        end
        if (em >= 0) begin
          if (we[k][em]) shadow[k][addr[k][em][7:0]] = wdata[k][em];
          active[k][em] = 1'b0; req[k][em] = 1'b0; foreign[k][em] = 0;
          if (active[k][1-em]) begin
            foreign[k][1-em]++;
            chk1("r_fair", foreign[k][1-em] <= 1, 1'b1);
          end
          if (req[k][1-em]) begin
            pend[k] = 1 - em; gcyc[k] = cyc; acyc[k] = cyc + 2 + k;
            last[k] = (em == 0);
          end else begin
            pend[k] = -1;
          end
        end else if (pend[k] < 0 && (req[k][0] || req[k][1])) begin
          win = (req[k][0] && req[k][1]) ? !last[k] : req[k][1];
          pend[k] = win ? 1 : 0; gcyc[k] = cyc; acyc[k] = cyc + 2 + k;
          last[k] = win;
        end
      end
      tick();
    end
    clr_all();
    for (int i = 0; i < 4; i++) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
